// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, bus field layouts,
// div_op bit positions and one-hot ALU operation indices.
package exe_stage_pkg;

    localparam int ID_TO_EXE_W  = 151;
    localparam int EXE_TO_MEM_W = 71;
    localparam int ALU_OP_W     = 12;

    // div_op = {en, signed, rem}
    localparam int DIV_EN_BIT     = 2;
    localparam int DIV_SIGNED_BIT = 1;
    localparam int DIV_REM_BIT    = 0;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    typedef struct packed {
        logic [31:0]         pc;
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic [2:0]          div_op;
        logic                res_from_mem;
        logic                mem_we;
        logic                rf_we;
        logic [4:0]          rf_waddr;
        logic [31:0]         store_data;
    } id_exe_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
    } exe_mem_bus_t;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Single-cycle integer ALU driven by a one-hot operation vector.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    output logic [31:0]         result
);

    logic [4:0]  sa;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] slt_r;
    logic [31:0] sltu_r;
    logic [31:0] sra_r;

    assign sa     = src2[4:0];
    assign sum    = src1 + src2;
    assign diff   = src1 - src2;
    assign slt_r  = {31'd0, $signed(src1) < $signed(src2)};
    assign sltu_r = {31'd0, src1 < src2};
    assign sra_r  = $signed(src1) >>> sa;

    assign result = ({32{alu_op[ALU_ADD]}}  & sum)
                  | ({32{alu_op[ALU_SUB]}}  & diff)
                  | ({32{alu_op[ALU_SLT]}}  & slt_r)
                  | ({32{alu_op[ALU_SLTU]}} & sltu_r)
                  | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                  | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                  | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                  | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                  | ({32{alu_op[ALU_SLL]}}  & (src1 << sa))
                  | ({32{alu_op[ALU_SRL]}}  & (src1 >> sa))
                  | ({32{alu_op[ALU_SRA]}}  & sra_r)
                  | ({32{alu_op[ALU_LUI]}}  & src2);

endmodule

// File: rtl/exe_stage_div_unit.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle, signed or unsigned.
//   state  | meaning
//   S_IDLE | waiting for start; operands latched on start
//   S_CALC | 32 shift/subtract steps, cnt counts completed steps
//   S_DONE | result held until ack
module div_unit
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;

    div_state_t  state;
    div_state_t  state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dsr;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] partial;
    logic        fits;
    logic        load;

    assign load    = (state == S_IDLE) && start;
    assign partial = {rem, quo[31]};
    assign fits    = partial >= {1'b0, dsr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= 5'd0;
            else if (state == S_CALC)
                cnt <= cnt + 5'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (cnt == 5'd31) state_nxt = S_DONE;
            S_DONE:  if (ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A zero divisor never flips the quotient, so it reads as all ones.
    always_ff @(posedge clk) begin
        if (load) begin
            quo   <= neg_if(dividend, is_signed && dividend[31]);
            dsr   <= neg_if(divisor, is_signed && divisor[31]);
            rem   <= 32'd0;
            neg_q <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
            neg_r <= is_signed && dividend[31];
        end else if (state == S_CALC) begin
            rem <= fits ? (partial[31:0] - dsr) : partial[31:0];
            quo <= {quo[30:0], fits};
        end
    end

    assign busy      = (state == S_CALC);
    assign done      = (state == S_DONE);
    assign quotient  = neg_if(quo, neg_q);
    assign remainder = neg_if(rem, neg_r);

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: ALU, multi-cycle divider, data SRAM request and
// hazard/forwarding information for the instruction held in EXE.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int ID_TO_EXE_BUS_WIDTH  = ID_TO_EXE_W,
    parameter int EXE_TO_MEM_BUS_WIDTH = EXE_TO_MEM_W
) (
    input  logic                            clk,
    input  logic                            resetn,
    output logic                            exe_allow_in,
    input  logic                            id_to_exe_valid,
    input  logic [ID_TO_EXE_BUS_WIDTH-1:0]  id_to_exe_bus,
    input  logic                            mem_allow_in,
    output logic                            exe_to_mem_valid,
    output logic [EXE_TO_MEM_BUS_WIDTH-1:0] exe_to_mem_bus,
    output logic                            exe_valid,
    output logic                            exe_rf_we,
    output logic [4:0]                      exe_rf_waddr,
    output logic                            exe_res_from_mem,
    output logic [31:0]                     exe_fwd_data,
    output logic                            data_sram_en,
    output logic [3:0]                      data_sram_we,
    output logic [31:0]                     data_sram_addr,
    output logic [31:0]                     data_sram_wdata
);

    logic [ID_TO_EXE_BUS_WIDTH-1:0] bus_r;
    id_exe_bus_t                    ib;
    exe_mem_bus_t                   ob;

    logic        exe_ready_go;
    logic        div_en;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] alu_result;
    logic [31:0] result;
    logic        mem_req;

    assign ib = bus_r;

    assign div_en           = ib.div_op[DIV_EN_BIT];
    assign exe_ready_go     = !div_en || div_done;
    assign exe_allow_in     = !exe_valid || (exe_ready_go && mem_allow_in);
    assign exe_to_mem_valid = exe_valid && exe_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            exe_valid <= 1'b0;
        else if (exe_allow_in)
            exe_valid <= id_to_exe_valid;
    end

    // Payload is only meaningful while exe_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (exe_allow_in && id_to_exe_valid)
            bus_r <= id_to_exe_bus;
    end

    alu u_alu (
        .alu_op (ib.alu_op),
        .src1   (ib.src1),
        .src2   (ib.src2),
        .result (alu_result)
    );

    assign div_start = exe_valid && div_en && !div_busy && !div_done;

    div_unit u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .is_signed (ib.div_op[DIV_SIGNED_BIT]),
        .dividend  (ib.src1),
        .divisor   (ib.src2),
        .ack       (exe_valid && mem_allow_in),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    assign result = div_en ? (ib.div_op[DIV_REM_BIT] ? div_r : div_q) : alu_result;

    assign ob.pc           = ib.pc;
    assign ob.result       = result;
    assign ob.res_from_mem = ib.res_from_mem;
    assign ob.rf_we        = ib.rf_we;
    assign ob.rf_waddr     = ib.rf_waddr;
    assign exe_to_mem_bus  = ob;

    // Request issues only on the cycle the instruction actually leaves EXE.
    assign mem_req         = ib.res_from_mem || ib.mem_we;
    assign data_sram_en    = exe_valid && exe_ready_go && mem_allow_in && mem_req;
    assign data_sram_we    = (data_sram_en && ib.mem_we) ? 4'hF : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = ib.store_data;

    assign exe_rf_we        = exe_valid && ib.rf_we;
    assign exe_rf_waddr     = ib.rf_waddr;
    assign exe_res_from_mem = exe_valid && ib.res_from_mem;
    assign exe_fwd_data     = result;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: behavioural reference model with per-cycle compare,
// directed literal cases and randomized instruction traffic.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         exe_allow_in;
    logic         id_to_exe_valid;
    logic [150:0] id_to_exe_bus;
    logic         mem_allow_in;
    logic         exe_to_mem_valid;
    logic [70:0]  exe_to_mem_bus;
    logic         exe_valid;
    logic         exe_rf_we;
    logic [4:0]   exe_rf_waddr;
    logic         exe_res_from_mem;
    logic [31:0]  exe_fwd_data;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    exe_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .exe_allow_in     (exe_allow_in),
        .id_to_exe_valid  (id_to_exe_valid),
        .id_to_exe_bus    (id_to_exe_bus),
        .mem_allow_in     (mem_allow_in),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .exe_valid        (exe_valid),
        .exe_rf_we        (exe_rf_we),
        .exe_rf_waddr     (exe_rf_waddr),
        .exe_res_from_mem (exe_res_from_mem),
        .exe_fwd_data     (exe_fwd_data),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: held instruction plus cycles left before it may leave.
    logic         m_valid = 1'b0;
    int           m_wait  = 0;
    logic [150:0] m_bus   = '0;

    task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [150:0] mk(input logic [31:0] pc, input int op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] dop, input logic rfm,
                                        input logic mwe, input logic rfwe,
                                        input logic [4:0] wa, input logic [31:0] sd);
        logic [11:0] oh;
        oh = 12'd1 << op;
        return {pc, oh, a, b, dop, rfm, mwe, rfwe, wa, sd};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        sa = a;
        if (op[ALU_ADD])  return a + b;
        if (op[ALU_SUB])  return a - b;
        if (op[ALU_SLT])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        if (op[ALU_SLTU]) return (a < b) ? 32'd1 : 32'd0;
        if (op[ALU_AND])  return a & b;
        if (op[ALU_NOR])  return ~(a | b);
        if (op[ALU_OR])   return a | b;
        if (op[ALU_XOR])  return a ^ b;
        if (op[ALU_SLL])  return a << b[4:0];
        if (op[ALU_SRL])  return a >> b[4:0];
        if (op[ALU_SRA])  return sa >>> b[4:0];
        if (op[ALU_LUI])  return b;
        return 32'd0;
    endfunction

    function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic rem);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            q = 32'h80000000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
        return rem ? r : q;
    endfunction

    function automatic logic [31:0] result_ref(input logic [150:0] b);
        if (b[42]) return div_ref(b[106:75], b[74:43], b[41], b[40]);
        return alu_ref(b[118:107], b[106:75], b[74:43]);
    endfunction

    task automatic compare();
        logic ready, mem, e_en;
        logic [31:0] res;
        ready = (m_wait == 0);
        res   = result_ref(m_bus);
        mem   = m_bus[39] | m_bus[38];
        e_en  = m_valid && ready && mem_allow_in && mem;
        chk("exe_valid", exe_valid, m_valid);
        chk("exe_allow_in", exe_allow_in, !m_valid || (ready && mem_allow_in));
        chk("exe_to_mem_valid", exe_to_mem_valid, m_valid && ready);
        chk("data_sram_en", data_sram_en, e_en);
        chk("data_sram_we", data_sram_we, (e_en && m_bus[38]) ? 4'hF : 4'h0);
        chk("exe_rf_we", exe_rf_we, m_valid && m_bus[37]);
        chk("exe_res_from_mem", exe_res_from_mem, m_valid && m_bus[39]);
        if (m_valid)
            chk("exe_rf_waddr", exe_rf_waddr, m_bus[36:32]);
        if (m_valid && ready) begin
            chk("exe_to_mem_bus", exe_to_mem_bus,
                {m_bus[150:119], res, m_bus[39], m_bus[37], m_bus[36:32]});
            chk("exe_fwd_data", exe_fwd_data, res);
        end
        if (e_en) begin
            chk("data_sram_addr", data_sram_addr, alu_ref(m_bus[118:107], m_bus[106:75], m_bus[74:43]));
            chk("data_sram_wdata", data_sram_wdata, m_bus[31:0]);
        end
    endtask

    task automatic update();
        logic ready, allow;
        if (!resetn) begin
            m_valid = 1'b0;
            m_wait  = 0;
            return;
        end
        ready = (m_wait == 0);
        allow = !m_valid || (ready && mem_allow_in);
        if (m_valid && !ready) m_wait--;
        if (allow) begin
            m_valid = id_to_exe_valid;
            if (id_to_exe_valid) begin
                m_bus  = id_to_exe_bus;
                m_wait = id_to_exe_bus[42] ? 33 : 0;
            end
        end
    endtask

    task automatic half_a();
        @(negedge clk);
        compare();
    endtask

    task automatic half_b();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic run_one(input string name, input logic [150:0] b,
                           input logic [31:0] exp_res, input int exp_wait);
        bit seen;
        id_to_exe_bus   = b;
        id_to_exe_valid = 1'b1;
        mem_allow_in    = 1'b1;
        half_a();
        half_b();
        id_to_exe_valid = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            half_a();
            if (exe_to_mem_valid) begin
                seen = 1'b1;
                chk({name, " result"}, exe_to_mem_bus[38:7], exp_res);
                chk({name, " wait"}, n, exp_wait);
                chk({name, " allow_in"}, exe_allow_in, 1'b1);
            end
            half_b();
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no exe_to_mem_valid in 100 cycles, expected after %0d", name, exp_wait);
        end
    endtask

    task automatic rand_inputs();
        logic [31:0] a, b;
        logic [2:0]  dop;
        logic        rfm, mwe;
        int          op;
        op  = $urandom_range(0, 11);
        a   = $urandom;
        b   = $urandom;
        case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = $urandom_range(1, 9);
            3: b = -($urandom_range(1, 9));
            default: ;
        endcase
        dop = 3'b000;
        rfm = 1'b0;
        mwe = 1'b0;
        if ($urandom_range(0, 3) == 0)
            dop = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        else if ($urandom_range(0, 3) == 0)
            rfm = 1'b1;
        else if ($urandom_range(0, 2) == 0)
            mwe = 1'b1;
        id_to_exe_bus   = mk($urandom, op, a, b, dop, rfm, mwe, 1'($urandom_range(0, 1)),
                             5'($urandom_range(0, 31)), $urandom);
        id_to_exe_valid = ($urandom_range(0, 9) < 7);
        mem_allow_in    = ($urandom_range(0, 9) < 6);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        resetn          = 1'b0;
        id_to_exe_valid = 1'b0;
        mem_allow_in    = 1'b0;
        id_to_exe_bus   = '0;
        #1;
        half_a();
        chk("reset exe_valid", exe_valid, 1'b0);
        chk("reset allow_in", exe_allow_in, 1'b1);
        chk("reset to_mem_valid", exe_to_mem_valid, 1'b0);
        chk("reset sram_en", data_sram_en, 1'b0);
        chk("reset sram_we", data_sram_we, 4'h0);
        half_b();
        half_a();
        half_b();
        resetn = 1'b1;
        half_a();
        half_b();

        run_one("add 5+7", mk(32'h1C000000, ALU_ADD, 32'd5, 32'd7, 3'b000, 0, 0, 1, 5'd3, 0), 32'd12, 0);
        run_one("sdiv -7/2", mk(32'h1C000004, ALU_ADD, 32'hFFFFFFF9, 32'd2, 3'b110, 0, 0, 1, 5'd4, 0),
                32'hFFFFFFFD, 33);
        run_one("smod -7/2", mk(32'h1C000008, ALU_ADD, 32'hFFFFFFF9, 32'd2, 3'b111, 0, 0, 1, 5'd5, 0),
                32'hFFFFFFFF, 33);
        run_one("udiv 100/0", mk(32'h1C00000C, ALU_ADD, 32'd100, 32'd0, 3'b100, 0, 0, 1, 5'd6, 0),
                32'hFFFFFFFF, 33);
        run_one("umod 100/0", mk(32'h1C000010, ALU_ADD, 32'd100, 32'd0, 3'b101, 0, 0, 1, 5'd7, 0),
                32'd100, 33);
        run_one("sdiv min/-1", mk(32'h1C000014, ALU_ADD, 32'h80000000, 32'hFFFFFFFF, 3'b110, 0, 0, 1, 5'd8, 0),
                32'h80000000, 33);

        // Store held by memory stage for three cycles.
        id_to_exe_bus   = mk(32'h1C000018, ALU_ADD, 32'h10, 32'hC, 3'b000, 0, 1, 0, 5'd0, 32'hDEADBEEF);
        id_to_exe_valid = 1'b1;
        mem_allow_in    = 1'b1;
        half_a();
        half_b();
        id_to_exe_valid = 1'b0;
        mem_allow_in    = 1'b0;
        pulses = 0;
        repeat (3) begin
            half_a();
            if (data_sram_en) pulses++;
            chk("store held sram_en", data_sram_en, 1'b0);
            half_b();
        end
        mem_allow_in = 1'b1;
        half_a();
        if (data_sram_en) pulses++;
        chk("store release sram_en", data_sram_en, 1'b1);
        chk("store release sram_we", data_sram_we, 4'hF);
        chk("store release addr", data_sram_addr, 32'h1C);
        chk("store release wdata", data_sram_wdata, 32'hDEADBEEF);
        half_b();
        half_a();
        if (data_sram_en) pulses++;
        half_b();
        chk("store pulse count", pulses, 1);

        // Reset pulse in the middle of a divide.
        id_to_exe_bus   = mk(32'h1C00001C, ALU_ADD, 32'hFFFFFFF9, 32'd2, 3'b110, 0, 0, 1, 5'd9, 0);
        id_to_exe_valid = 1'b1;
        half_a();
        half_b();
        id_to_exe_valid = 1'b0;
        repeat (11) begin
            half_a();
            half_b();
        end
        resetn  = 1'b0;
        m_valid = 1'b0;
        m_wait  = 0;
        half_a();
        chk("abort exe_valid", exe_valid, 1'b0);
        chk("abort allow_in", exe_allow_in, 1'b1);
        chk("abort to_mem_valid", exe_to_mem_valid, 1'b0);
        chk("abort sram_en", data_sram_en, 1'b0);
        half_b();
        resetn = 1'b1;
        repeat (3) begin
            half_a();
            chk("post-abort to_mem_valid", exe_to_mem_valid, 1'b0);
            half_b();
        end
        run_one("add after abort", mk(32'h1C000020, ALU_ADD, 32'd3, 32'd4, 3'b000, 0, 0, 1, 5'd10, 0), 32'd7, 0);

        repeat (2500) begin
            rand_inputs();
            half_a();
            half_b();
        end

        id_to_exe_valid = 1'b0;
        mem_allow_in    = 1'b1;
        repeat (40) begin
            half_a();
            half_b();
        end
        half_a();
        chk("drained exe_valid", exe_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
